regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Round-robin arbiter and sequencer that shares the single write port of the multi-ported, file-initialised register file among three requesters. Each requester presents a valid/ready write request. The arbiter registers one winning write per cycle onto the register file's write port and exposes the in-flight write so read-side logic can bypass it. An optional clear sequencer sweeps the whole address range to zero on command.

## Interface
- addr_width, 5, register file address width
- data_width, 32, register file data width
- lo, 0, lowest valid address
- hi, 31, highest valid address; lo <= hi < 2**addr_width
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ_VALID  in  3  per-requester write request, bit i = requester i
- REQ_ADDR_0 / REQ_ADDR_1 / REQ_ADDR_2  in  addr_width  write address per requester
- REQ_DATA_0 / REQ_DATA_1 / REQ_DATA_2  in  data_width  write data per requester
- REQ_READY  out  3  one-hot grant; handshake completes on VALID[i] & READY[i] at the rising edge
- CLEAR_START  in  1  single-cycle request to zero the file
- CLEAR_BUSY  out  1  clear sweep in progress
- RF_ADDR_IN  out  addr_width  to register file write address
- RF_D_IN  out  data_width  to register file write data
- RF_WE  out  1  to register file write enable
- WR_PENDING  out  1  equals RF_WE; a write lands at the next edge
- ERR_ADDR  out  1  sticky: an accepted request had an address outside lo..hi

## Operation
- FSM states:
  - IDLE: arbitrate.
  - CLEAR: sweep the address range.
- IDLE, no CLEAR_START: grant at most one requester per cycle.
  - Search order starts at rr_ptr and wraps modulo 3.
  - First requester with VALID set gets READY; all other READY bits are 0.
  - REQ_READY is combinational from REQ_VALID, rr_ptr and state. It never asserts for a requester whose VALID is low.
  - On handshake with requester i: rr_ptr <= (i+1) mod 3. Without a handshake rr_ptr holds.
- A requester holds VALID, ADDR and DATA stable until its handshake. Dropping VALID early is legal; the arbiter keeps no state for it.
- Accepted request with lo <= addr <= hi: next cycle RF_WE=1 with the registered addr and data.
- Accepted request with addr outside lo..hi: handshake completes and the write is dropped (RF_WE=0). ERR_ADDR sets and stays set until reset.
- Output stage is a single register. It always drains in one cycle, so sustained throughput is one write per cycle.
- CLEAR_START in IDLE: go to CLEAR with sweep counter = lo.
  - REQ_READY is forced to 000 in the same cycle, and CLEAR wins over any pending request.
  - Each cycle in CLEAR: write 0 to the counter address, then increment the counter.
  - After address hi is issued, return to IDLE.
  - rr_ptr is preserved across a clear.
- CLEAR_START while in CLEAR is ignored.
- Reset (async, any time, including mid-sweep or mid-write) forces:
  - state IDLE, rr_ptr 0, ERR_ADDR 0, CLEAR_BUSY 0
  - RF_WE 0, WR_PENDING 0, RF_ADDR_IN 0, RF_D_IN 0
- An aborted sweep leaves the file partially cleared. No resume after reset.

## Timing
- Handshake at edge t drives RF_WE, RF_ADDR_IN and RF_D_IN valid during cycle t+1. The array updates at edge t+1, and read ports see new data in cycle t+2.
- WR_PENDING and RF_ADDR_IN during t+1 let read-side logic bypass.
- CLEAR_START sampled at edge t:
  - CLEAR_BUSY=1 and REQ_READY=000 from cycle t+1.
  - First clear write (RF_WE=1, addr lo, data 0) in cycle t+1.
  - Last clear write (addr hi) in cycle t+1+(hi-lo).
  - CLEAR_BUSY=0 and arbitration resumes in cycle t+2+(hi-lo).
  - Sweep length is exactly hi-lo+1 write cycles.
- A write accepted at edge t with CLEAR_START also sampled at t: the accepted write issues in t+1, and the sweep starts in t+2.
  - Normally the combinational READY gating makes this impossible. Any accepted write always completes before the sweep.
- No combinational path from REQ_* to RF_*. RF_* are driven from flops only.

## Configuration
- REGFILE_ARB_CLEAR_EN defined: CLEAR state, sweep counter and CLEAR_START handling are compiled in as above.
- REGFILE_ARB_CLEAR_EN undefined:
  - The FSM is IDLE only.
  - CLEAR_START is ignored and CLEAR_BUSY is tied to 0.
  - No sweep counter logic is present.
  - Arbitration and timing are otherwise identical.

## Test plan
- Single request: after reset, VALID=001, ADDR_0=5, DATA_0=0xDEADBEEF.
  - Required: READY=001 the same cycle.
  - Next cycle: RF_WE=1, RF_ADDR_IN=5, RF_D_IN=0xDEADBEEF.
  - Read port at address 5 returns 0xDEADBEEF two cycles after the handshake.
- Fairness: VALID=111 held for 6 cycles.
  - Required grant sequence: 001, 010, 100, 001, 010, 100.
  - Six consecutive RF_WE pulses carrying each requester's data.
- Out-of-range (lo=0, hi=15, addr_width=5): requester 1 writes addr 20.
  - Required: handshake completes, RF_WE stays 0, ERR_ADDR=1 until reset.
- Clear (macro on, lo=0, hi=31): pulse CLEAR_START with VALID=111.
  - Required: REQ_READY=000 and CLEAR_BUSY=1 for 32 cycles.
  - RF_WE writes 0 to addresses 0..31 in order.
  - Arbitration resumes at rr_ptr's pre-clear value.
- Reset mid-sweep: assert RST_N=0 at sweep address 10.
  - Required: RF_WE=0 immediately (asynchronously), CLEAR_BUSY=0, rr_ptr=0.
  - Addresses 10..31 keep their prior contents.
- Macro off: pulse CLEAR_START while VALID=010.
  - Required: CLEAR_BUSY stays 0, READY=010, and the normal write occurs.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bundle between three requesters and the register-file write arbiter,
// together with the arbiter's register-file write port and status flags.
interface regfile_write_arbiter_if #(
    parameter int addr_width = 5,
    parameter int data_width = 32
);
    logic [2:0]            REQ_VALID;
    logic [addr_width-1:0] REQ_ADDR_0;
    logic [addr_width-1:0] REQ_ADDR_1;
    logic [addr_width-1:0] REQ_ADDR_2;
    logic [data_width-1:0] REQ_DATA_0;
    logic [data_width-1:0] REQ_DATA_1;
    logic [data_width-1:0] REQ_DATA_2;
    logic [2:0]            REQ_READY;
    logic                  CLEAR_START;
    logic                  CLEAR_BUSY;
    logic [addr_width-1:0] RF_ADDR_IN;
    logic [data_width-1:0] RF_D_IN;
    logic                  RF_WE;
    logic                  WR_PENDING;
    logic                  ERR_ADDR;

    modport master (
        output REQ_VALID, REQ_ADDR_0, REQ_ADDR_1, REQ_ADDR_2,
               REQ_DATA_0, REQ_DATA_1, REQ_DATA_2, CLEAR_START,
        input  REQ_READY, CLEAR_BUSY, RF_ADDR_IN, RF_D_IN, RF_WE,
               WR_PENDING, ERR_ADDR
    );

    modport slave (
        input  REQ_VALID, REQ_ADDR_0, REQ_ADDR_1, REQ_ADDR_2,
               REQ_DATA_0, REQ_DATA_1, REQ_DATA_2, CLEAR_START,
        output REQ_READY, CLEAR_BUSY, RF_ADDR_IN, RF_D_IN, RF_WE,
               WR_PENDING, ERR_ADDR
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter owning the register file's single write port for three requesters.
// Zero-sweep clear sequencer is compiled in only when REGFILE_ARB_CLEAR_EN is defined.
//
// state   | meaning
// IDLE    | arbitrate requesters, at most one registered write per cycle
// CLEAR   | sweep lo..hi writing zero, all READY held low
module regfile_write_arbiter #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int lo         = 0,
    parameter int hi         = 31
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    regfile_write_arbiter_if.slave bus
);
    localparam logic [addr_width-1:0] LO_A  = addr_width'(lo);
    localparam logic [addr_width-1:0] HI_A  = addr_width'(hi);
    localparam logic [addr_width-1:0] ONE_A = addr_width'(1);

    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic                  rf_we_q, rf_we_d;
    logic [addr_width-1:0] rf_addr_q, rf_addr_d;
    logic [data_width-1:0] rf_data_q, rf_data_d;
    logic                  err_q, err_d;

    logic [2:0]            grant;
    logic [2:0]            ready;
    logic                  hs;
    logic [1:0]            hs_idx;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_data;
    logic                  in_range;

    logic                  clear_go;
    logic                  clear_busy;
    logic                  sweep_adv;
    logic [addr_width-1:0] sweep_next;

`ifdef REGFILE_ARB_CLEAR_EN
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [addr_width-1:0] sweep_q, sweep_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // sweep_q tracks the address currently presented on the write port while clearing
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            S_IDLE: begin
                if (bus.CLEAR_START) begin
                    state_d = S_CLEAR;
                    sweep_d = LO_A;
                end
            end
            S_CLEAR: begin
                if (sweep_q == HI_A) state_d = S_IDLE;
                else                 sweep_d = sweep_q + ONE_A;
            end
        endcase
    end

    assign clear_busy = (state_q == S_CLEAR);
    assign clear_go   = (state_q == S_IDLE) && bus.CLEAR_START;
    assign sweep_adv  = clear_busy && (sweep_q != HI_A);
    assign sweep_next = sweep_q + ONE_A;
`else
    logic unused_clear_start;
    assign unused_clear_start = bus.CLEAR_START;
    assign clear_busy         = 1'b0;
    assign clear_go           = 1'b0;
    assign sweep_adv          = 1'b0;
    assign sweep_next         = '0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr_q  <= 2'd0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        grant = 3'b000;
        case (rr_ptr_q)
            2'd1: begin
                if      (bus.REQ_VALID[1]) grant = 3'b010;
                else if (bus.REQ_VALID[2]) grant = 3'b100;
                else if (bus.REQ_VALID[0]) grant = 3'b001;
            end
            2'd2: begin
                if      (bus.REQ_VALID[2]) grant = 3'b100;
                else if (bus.REQ_VALID[0]) grant = 3'b001;
                else if (bus.REQ_VALID[1]) grant = 3'b010;
            end
            default: begin
                if      (bus.REQ_VALID[0]) grant = 3'b001;
                else if (bus.REQ_VALID[1]) grant = 3'b010;
                else if (bus.REQ_VALID[2]) grant = 3'b100;
            end
        endcase

        // a clear request wins in the very cycle it is seen
        ready = (clear_go || clear_busy) ? 3'b000 : grant;
        hs    = |ready;

        hs_idx   = 2'd0;
        sel_addr = bus.REQ_ADDR_0;
        sel_data = bus.REQ_DATA_0;
        if (ready[1]) begin
            hs_idx   = 2'd1;
            sel_addr = bus.REQ_ADDR_1;
            sel_data = bus.REQ_DATA_1;
        end else if (ready[2]) begin
            hs_idx   = 2'd2;
            sel_addr = bus.REQ_ADDR_2;
            sel_data = bus.REQ_DATA_2;
        end
        in_range = (int'(sel_addr) >= lo) && (int'(sel_addr) <= hi);

        rr_ptr_d = rr_ptr_q;
        if (hs) rr_ptr_d = (hs_idx == 2'd2) ? 2'd0 : hs_idx + 2'd1;

        err_d = err_q | (hs & ~in_range);

        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (clear_go) begin
            rf_we_d   = 1'b1;
            rf_addr_d = LO_A;
            rf_data_d = '0;
        end else if (sweep_adv) begin
            rf_we_d   = 1'b1;
            rf_addr_d = sweep_next;
            rf_data_d = '0;
        end else if (hs && in_range) begin
            rf_we_d   = 1'b1;
            rf_addr_d = sel_addr;
            rf_data_d = sel_data;
        end
    end

    assign bus.REQ_READY  = ready;
    assign bus.CLEAR_BUSY = clear_busy;
    assign bus.RF_ADDR_IN = rf_addr_q;
    assign bus.RF_D_IN    = rf_data_q;
    assign bus.RF_WE      = rf_we_q;
    assign bus.WR_PENDING = rf_we_q;
    assign bus.ERR_ADDR   = err_q;
endmodule
